seg_display_scheduler: RTL
==========================

// Module: seg_display_scheduler
// PURPOSE
//  Owns the 3-digit 7-seg score display and shares it between two sources: live score and best score.
//  Converts the selected 8-bit binary value to BCD with a sequential double-dabble (no dividers).
//  Loads the three digits atomically into display registers, then scans them with an anti-ghost blanking gap.
//  Sits between game logic (score/best counters) and the board's sel/DIG pins.
// PARAMETERS
//  SCAN_DIV      128   clk cycles per digit slot (>= BLANK_CYCLES+1)
//  BLANK_CYCLES  4     cycles at end of each slot with all digits off
//  HOLD_CYCLES   1024  cycles the best score owns the display after a best_req
// PORTS
//  clk       in   1  system clock, all logic on posedge
//  rst_n     in   1  reset, synchronous, active-low
//  score     in   8  live score, binary 0..255
//  best      in   8  best score, binary 0..255
//  best_req  in   1  1-cycle pulse: show best for HOLD_CYCLES
//  freeze    in   1  level: inhibit digit-register loads (scan continues)
//  sel       out  3  digit enables, active-low: 011=units, 101=tens, 110=hundreds, 111=off
//  DIG       out  7  segments g..a, active-low (0=1000000 ... 9=0011000)
//  busy      out  1  conversion in progress
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): sel=111, DIG=1111111, busy=0, digit regs=0, src=LIVE, conv=IDLE,
//    scan idx=0, scan/hold counters=0, loaded_valid=0. Applies even mid-conversion (conversion discarded).
//  Source FSM: LIVE -> BEST on best_req; BEST -> LIVE when hold counter reaches HOLD_CYCLES-1.
//    best_req while in BEST restarts the hold counter at 0. src_val = (src==BEST) ? best : score.
//  Conversion FSM: IDLE -> SHIFT when !freeze && (!loaded_valid || src_val != last_val). On entry, capture src_val.
//    SHIFT: 8 cycles of add-3-then-shift. LOAD: 1 cycle.
//    LOAD writes hundreds/tens/units together, sets last_val and loaded_valid=1, then -> IDLE.
//    Latency: input change to new digit registers = 10 cycles (1 detect + 8 shift + 1 load).
//  A source switch during SHIFT aborts the conversion and restarts it on the new src_val.
//    Digit registers are unchanged until a conversion completes.
//  A value change on the same source during SHIFT does not abort.
//    The in-flight conversion loads, then the mismatch starts a new conversion in the next cycle.
//  freeze=1: no new conversion starts and LOAD is suppressed (result dropped, loaded_valid unchanged).
//    On release, the mismatch check reconverts.
//  busy=1 in SHIFT and LOAD states.
//  Scan: counter 0..SCAN_DIV-1. On wrap, idx advances 0->1->2->0. idx selects sel and DIG from that digit register.
//    While counter >= SCAN_DIV-BLANK_CYCLES: sel=111, DIG=1111111.
//    sel/DIG are registered: one cycle behind counter and idx.
//  Arithmetic: 8-bit in, 10-bit BCD shift reg (hundreds max 2). Values 0..255 are exact. No saturation needed.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: hundreds blanked (sel=111) when it is 0.
//    Tens also blanked when hundreds and tens are both 0. Units are always shown ("  7").
//  Undefined: all three digits always driven ("007").
// STRUCTURE
//  Package seg_pkg: SEG_BLANK=7'b1111111, SEL_UNITS/TENS/HUNDREDS/OFF codes,
//    function seg_encode(bcd) (active-low table, default blank), src_e {LIVE,BEST}, conv_e {IDLE,SHIFT,LOAD}.
//  Sub-module seg_bin2bcd: start/value in, done/bcd[9:0] out, abort input. Holds the conversion FSM and shift register.
//  Top module: source FSM, hold timer, digit registers, scanner.
// TESTING  (bench params SCAN_DIV=8, BLANK_CYCLES=2, HOLD_CYCLES=32)
//  1 rst_n=0 for 3 clk, score=0 -> sel=111, DIG=1111111, busy=0.
//    Release -> within 10 clk digits 0/0/0. Units slot: sel=011, DIG=1000000.
//  2 score 0->137 -> busy high 9 clk. Digits become 1/3/7 after 10 clk.
//    Slot order sel 011,101,110 shows DIG 1111000, 0110000, 1111001.
//  3 Blanking: in every slot, counter 6..7 -> sel=111, DIG=1111111. Non-blank cycles per slot=6. score=255 -> 2/5/5.
//  4 score=12, best=42, pulse best_req -> digits 0/4/2 within 10 clk. Hold 32 clk, then back to 0/1/2.
//    Second best_req 16 clk into the hold -> BEST lasts 32 clk from the second pulse.
//  5 best_req 3 clk into a score conversion -> conversion aborts. Only 0/4/2 ever loads (no stale score flash).
//  6 freeze=1, score 50->99 -> digits stay 0/5/0, busy=0. freeze=0 -> 0/9/9 after 10 clk.
//    With LEADING_ZERO_BLANK_EN: hundreds slot sel=111.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the 3-digit seven-segment score display.
//   SEG_BLANK          : all segments off (active-low)
//   SEL_*              : active-low digit-enable codes
//   seg_encode()       : BCD digit to active-low g..a pattern, blank for non-decimal codes
//   src_e / conv_e     : display source and converter state encodings
package seg_pkg;

    localparam logic [6:0] SEG_BLANK    = 7'b1111111;
    localparam logic [2:0] SEL_UNITS    = 3'b011;
    localparam logic [2:0] SEL_TENS     = 3'b101;
    localparam logic [2:0] SEL_HUNDREDS = 3'b110;
    localparam logic [2:0] SEL_OFF      = 3'b111;

    typedef enum logic {
        LIVE,
        BEST
    } src_e;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } conv_e;

    function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0011000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_bin2bcd.sv
// Sequential double-dabble converter: 8-bit binary to 10-bit BCD in 8 shift cycles.
//   clk, rst_n : clock, synchronous active-low reset
//   start_i    : begin a conversion of value_i (honoured only when idle)
//   abort_i    : drop an in-flight conversion while shifting
//   value_i    : binary value to convert
//   busy_o     : high in SHIFT and LOAD
//   done_o     : one-cycle strobe in LOAD; bcd_o/value_o valid
//   bcd_o      : {hundreds[1:0], tens[3:0], units[3:0]}
//   value_o    : binary value the current result belongs to
module seg_bin2bcd
    import seg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [7:0] value_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [9:0] bcd_o,
    output logic [7:0] value_o
);

    conv_e      state_q, state_d;
    logic [7:0] bin_q, bin_d;
    logic [9:0] bcd_q, bcd_d;
    logic [7:0] val_q, val_d;
    logic [2:0] cnt_q, cnt_d;
    logic [8:0] adj;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        val_d   = val_q;
        cnt_d   = cnt_q;

        // Add-3 on the tens/units nibbles; hundreds never exceeds 2 so needs no adjust.
        adj = bcd_q[8:0];
        if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
        if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = SHIFT;
                    bin_d   = value_i;
                    val_d   = value_i;
                    bcd_d   = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    bcd_d = {adj, bin_q[7]};
                    bin_d = {bin_q[6:0], 1'b0};
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_d = LOAD;
                end
            end
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            val_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            val_q   <= val_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o  = (state_q != IDLE);
    assign done_o  = (state_q == LOAD);
    assign bcd_o   = bcd_q;
    assign value_o = val_q;

endmodule

// File: rtl/seg_display_scheduler.sv
// Shares a 3-digit seven-segment display between the live score and the best score,
// converts the selected value to BCD, loads the digits atomically and scans them with
// a blanking gap at the end of each digit slot.
//   clk, rst_n : clock, synchronous active-low reset
//   score      : live score (binary)
//   best       : best score (binary)
//   best_req   : one-cycle pulse, show best for HOLD_CYCLES
//   freeze     : inhibit starting conversions and loading digits; scanning continues
//   sel        : active-low digit enables (011 units, 101 tens, 110 hundreds, 111 off)
//   DIG        : active-low segments g..a
//   busy       : conversion in progress
// Build option: LEADING_ZERO_BLANK_EN blanks a zero hundreds digit, and the tens digit
// too when both are zero.
module seg_display_scheduler
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 128,
    parameter int unsigned BLANK_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] score,
    input  logic [7:0] best,
    input  logic       best_req,
    input  logic       freeze,
    output logic [2:0] sel,
    output logic [6:0] DIG,
    output logic       busy
);

    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES);
    localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCAN_W-1:0] BLANK_FROM = SCAN_W'(SCAN_DIV - BLANK_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);

    src_e              src_q, src_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [1:0]        idx_q, idx_d;
    logic [1:0]        hund_q;
    logic [3:0]        tens_q, units_q;
    logic [7:0]        last_val_q;
    logic              loaded_valid_q;
    logic [2:0]        sel_q, sel_d;
    logic [6:0]        dig_q, dig_d;

    logic [7:0] src_val;
    logic       conv_start, conv_abort, conv_busy, conv_done;
    logic [9:0] conv_bcd;
    logic [7:0] conv_val;

    // Source selection and best-score hold timer.
    always_comb begin
        src_d  = src_q;
        hold_d = hold_q;
        if (best_req) begin
            src_d  = BEST;
            hold_d = '0;
        end else if (src_q == BEST) begin
            if (hold_q == HOLD_LAST) begin
                src_d  = LIVE;
                hold_d = '0;
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end
    end

    assign src_val    = (src_q == BEST) ? best : score;
    assign conv_start = !freeze && (!loaded_valid_q || (src_val != last_val_q));
    // A source switch makes any in-flight result stale.
    assign conv_abort = (src_d != src_q);

    seg_bin2bcd u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (conv_start),
        .abort_i (conv_abort),
        .value_i (src_val),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd),
        .value_o (conv_val)
    );

    // Scan position and registered digit drive.
    always_comb begin
        scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + SCAN_W'(1);
        idx_d  = idx_q;
        if (scan_q == SCAN_LAST) idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;

        sel_d = SEL_OFF;
        dig_d = SEG_BLANK;
        if (scan_q < BLANK_FROM) begin
            case (idx_q)
                2'd0: begin
                    sel_d = SEL_UNITS;
                    dig_d = seg_encode(units_q);
                end
                2'd1: begin
`ifdef LEADING_ZERO_BLANK_EN
                    if (!((hund_q == 2'd0) && (tens_q == 4'd0))) begin
                        sel_d = SEL_TENS;
                        dig_d = seg_encode(tens_q);
                    end
`else
                    sel_d = SEL_TENS;
                    dig_d = seg_encode(tens_q);
`endif
                end
                default: begin
`ifdef LEADING_ZERO_BLANK_EN
                    if (hund_q != 2'd0) begin
                        sel_d = SEL_HUNDREDS;
                        dig_d = seg_encode({2'b00, hund_q});
                    end
`else
                    sel_d = SEL_HUNDREDS;
                    dig_d = seg_encode({2'b00, hund_q});
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_q          <= LIVE;
            hold_q         <= '0;
            scan_q         <= '0;
            idx_q          <= '0;
            hund_q         <= '0;
            tens_q         <= '0;
            units_q        <= '0;
            last_val_q     <= '0;
            loaded_valid_q <= 1'b0;
            sel_q          <= SEL_OFF;
            dig_q          <= SEG_BLANK;
        end else begin
            src_q  <= src_d;
            hold_q <= hold_d;
            scan_q <= scan_d;
            idx_q  <= idx_d;
            sel_q  <= sel_d;
            dig_q  <= dig_d;
            // Frozen results are dropped; the mismatch check reconverts after release.
            if (conv_done && !freeze) begin
                hund_q         <= conv_bcd[9:8];
                tens_q         <= conv_bcd[7:4];
                units_q        <= conv_bcd[3:0];
                last_val_q     <= conv_val;
                loaded_valid_q <= 1'b1;
            end
        end
    end

    assign sel  = sel_q;
    assign DIG  = dig_q;
    assign busy = conv_busy;

endmodule
